// File: rtl/apu_square_ch1_if.sv
// CPU-side register bus of APU channel 1: write strobe, read cycle, NR10..NR14
// selects, write data and the read-back path driven by the channel.
interface apu_square_ch1_if;
   logic       apu_wr;
   logic       cpu_rd;
   logic       ff10;
   logic       ff11;
   logic       ff12;
   logic       ff13;
   logic       ff14;
   logic [7:0] d;
   logic [7:0] ch1_d_out;
   logic       ch1_d_oe;

   modport master (
      output apu_wr, cpu_rd, ff10, ff11, ff12, ff13, ff14, d,
      input  ch1_d_out, ch1_d_oe
   );

   modport slave (
      input  apu_wr, cpu_rd, ff10, ff11, ff12, ff13, ff14, d,
      output ch1_d_out, ch1_d_oe
   );
endinterface

// File: rtl/apu_square_ch1.sv
// APU channel 1: square wave with length counter, volume envelope and, when
// APU_CH1_SWEEP_EN is defined, the NR10 frequency sweep unit.
module apu_square_ch1 #(
   parameter int FREQ_W = 11,
   parameter int LEN_W  = 6
) (
   input  logic            apuv_4mhz,
   input  logic            napu_reset,
   apu_square_ch1_if.slave bus,
   input  logic            fs_tick,
   output logic [3:0]      ch1_out,
   output logic            nch1_active,
   output logic            nch1_amp_en
);
   localparam logic [FREQ_W-1:0] FREQ_MAX = {FREQ_W{1'b1}};
   localparam logic [FREQ_W-1:0] FREQ_ONE = {{(FREQ_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W:0]    LEN_MAX  = {1'b1, {LEN_W{1'b0}}};
   localparam logic [LEN_W:0]    LEN_ZERO = {(LEN_W+1){1'b0}};
   localparam logic [LEN_W:0]    LEN_ONE  = {{LEN_W{1'b0}}, 1'b1};

   // Pattern bit n is the output level at duty index n.
   function automatic logic [7:0] duty_pattern(input logic [1:0] duty);
      case (duty)
         2'b00:   duty_pattern = 8'b1000_0000;
         2'b01:   duty_pattern = 8'b1000_0001;
         2'b10:   duty_pattern = 8'b1110_0001;
         2'b11:   duty_pattern = 8'b0111_1110;
         default: duty_pattern = 8'b0000_0000;
      endcase
   endfunction

`ifdef APU_CH1_SWEEP_EN
   function automatic logic [FREQ_W:0] sweep_calc(input logic [FREQ_W-1:0] f,
                                                   input logic neg, input logic [2:0] sh);
      logic [FREQ_W:0] base;
      logic [FREQ_W:0] delta;
      base  = {1'b0, f};
      delta = {1'b0, f >> sh};
      sweep_calc = neg ? (base - delta) : (base + delta);
   endfunction

   logic [6:0]        nr10_r, nr10_nx;
   logic [FREQ_W-1:0] shadow_r, shadow_nx;
   logic [3:0]        sw_tmr_r, sw_tmr_nx, sw_reload_s;
   logic              sweep_on_r, sweep_on_nx, sw_clk_s, wr10_s;
   logic [FREQ_W:0]   sw_new_s, sw_chk_s, trig_chk_s;
`endif

   logic [1:0]        pre_r;
   logic [FREQ_W-1:0] freq_r, freq_nx, ftmr_r, ftmr_nx;
   logic [2:0]        idx_r, idx_nx, fs_step_r, fs_step_nx, fs_step_inc_s;
   logic [1:0]        duty_r, duty_nx;
   logic [7:0]        nr12_r, nr12_nx, pat_s;
   logic              len_en_r, len_en_nx;
   logic [LEN_W:0]    len_r, len_nx;
   logic [3:0]        vol_r, vol_nx, env_tmr_r, env_tmr_nx, env_reload_s, out_r, out_nx;
   logic              env_frz_r, env_frz_nx, active_r, active_nx, amp_n_r, amp_n_nx;
   logic              sel_any_s, wr_any_s, wr11_s, wr12_s, wr13_s, wr14_s, trig_s;
   logic              tick1m_s, fs_en_s, len_clk_s, env_clk_s, len_expire_s, sweep_kill_s;

   assign sel_any_s     = bus.ff10 | bus.ff11 | bus.ff12 | bus.ff13 | bus.ff14;
   assign wr_any_s      = bus.apu_wr & sel_any_s;
   assign wr11_s        = bus.apu_wr & bus.ff11;
   assign wr12_s        = bus.apu_wr & bus.ff12;
   assign wr13_s        = bus.apu_wr & bus.ff13;
   assign wr14_s        = bus.apu_wr & bus.ff14;
   assign trig_s        = wr14_s & bus.d[7];
   assign tick1m_s      = &pre_r;
   // Any register write in the same cycle swallows the frame-sequencer tick.
   assign fs_en_s       = fs_tick & ~wr_any_s;
   assign fs_step_inc_s = fs_step_r + 3'd1;
   assign len_clk_s     = fs_en_s & ~fs_step_inc_s[0];
   assign env_clk_s     = fs_en_s & (fs_step_inc_s == 3'd7);
   assign len_expire_s  = len_clk_s & len_en_r & (len_r == LEN_ONE);
   assign env_reload_s  = (nr12_r[2:0] == 3'd0) ? 4'd8 : {1'b0, nr12_r[2:0]};
   assign pat_s         = duty_pattern(duty_r);

   // Next-state logic for all channel state.
   always_comb begin
      duty_nx      = wr11_s ? bus.d[7:6] : duty_r;
      nr12_nx      = wr12_s ? bus.d : nr12_r;
      amp_n_nx     = wr12_s ? ~|bus.d[7:3] : amp_n_r;
      len_en_nx    = wr14_s ? bus.d[6] : len_en_r;
      freq_nx      = freq_r;
      freq_nx[7:0] = wr13_s ? bus.d : freq_r[7:0];
      freq_nx[FREQ_W-1:8] = wr14_s ? bus.d[FREQ_W-9:0] : freq_r[FREQ_W-1:8];
      fs_step_nx   = fs_en_s ? fs_step_inc_s : fs_step_r;
      ftmr_nx      = ftmr_r;
      idx_nx       = idx_r;
      len_nx       = len_r;
      vol_nx       = vol_r;
      env_tmr_nx   = env_tmr_r;
      env_frz_nx   = env_frz_r;
      active_nx    = active_r;
      sweep_kill_s = 1'b0;

      if (trig_s) begin
         ftmr_nx = freq_nx;
      end else if (tick1m_s && (ftmr_r == FREQ_MAX)) begin
         ftmr_nx = freq_r;
         idx_nx  = idx_r + 3'd1;
      end else if (tick1m_s) begin
         ftmr_nx = ftmr_r + FREQ_ONE;
      end else begin
         ftmr_nx = ftmr_r;
      end

      if (wr11_s) begin
         len_nx = LEN_MAX - {1'b0, bus.d[LEN_W-1:0]};
      end else if (trig_s && (len_r == LEN_ZERO)) begin
         len_nx = LEN_MAX;
      end else if (len_clk_s && len_en_r && (len_r != LEN_ZERO)) begin
         len_nx = len_r - LEN_ONE;
      end else begin
         len_nx = len_r;
      end

      if (trig_s) begin
         vol_nx     = nr12_r[7:4];
         env_tmr_nx = env_reload_s;
         env_frz_nx = 1'b0;
      end else if (env_clk_s && (env_tmr_r > 4'd1)) begin
         env_tmr_nx = env_tmr_r - 4'd1;
      end else if (env_clk_s) begin
         env_tmr_nx = env_reload_s;
         if ((nr12_r[2:0] == 3'd0) || env_frz_r) begin
            vol_nx = vol_r;
         end else if (nr12_r[3] && (vol_r != 4'hF)) begin
            vol_nx = vol_r + 4'd1;
         end else if (!nr12_r[3] && (vol_r != 4'h0)) begin
            vol_nx = vol_r - 4'd1;
         end else begin
            env_frz_nx = 1'b1;
         end
      end else begin
         env_tmr_nx = env_tmr_r;
      end

`ifdef APU_CH1_SWEEP_EN
      nr10_nx     = wr10_s ? bus.d[6:0] : nr10_r;
      shadow_nx   = shadow_r;
      sw_tmr_nx   = sw_tmr_r;
      sweep_on_nx = sweep_on_r;
      sw_new_s    = sweep_calc(shadow_r, nr10_r[3], nr10_r[2:0]);
      sw_chk_s    = sweep_calc(sw_new_s[FREQ_W-1:0], nr10_r[3], nr10_r[2:0]);
      trig_chk_s  = sweep_calc(freq_nx, nr10_r[3], nr10_r[2:0]);
      if (trig_s) begin
         shadow_nx    = freq_nx;
         sw_tmr_nx    = sw_reload_s;
         sweep_on_nx  = (nr10_r[6:4] != 3'd0) || (nr10_r[2:0] != 3'd0);
         sweep_kill_s = (nr10_r[2:0] != 3'd0) && trig_chk_s[FREQ_W];
      end else if (sw_clk_s && (sw_tmr_r > 4'd1)) begin
         sw_tmr_nx = sw_tmr_r - 4'd1;
      end else if (sw_clk_s) begin
         sw_tmr_nx = sw_reload_s;
         if (!sweep_on_r || (nr10_r[6:4] == 3'd0)) begin
            sweep_kill_s = 1'b0;
         end else if (sw_new_s[FREQ_W]) begin
            sweep_kill_s = 1'b1;
         end else if (nr10_r[2:0] != 3'd0) begin
            shadow_nx    = sw_new_s[FREQ_W-1:0];
            freq_nx      = sw_new_s[FREQ_W-1:0];
            sweep_kill_s = sw_chk_s[FREQ_W];
         end else begin
            sweep_kill_s = 1'b0;
         end
      end else begin
         sw_tmr_nx = sw_tmr_r;
      end
`endif

      if (trig_s) begin
         active_nx = (|nr12_r[7:3]) & ~sweep_kill_s;
      end else if ((wr12_s && (bus.d[7:3] == 5'd0)) || len_expire_s || sweep_kill_s) begin
         active_nx = 1'b0;
      end else begin
         active_nx = active_r;
      end

      out_nx = (active_nx && pat_s[idx_r]) ? vol_r : 4'd0;
   end

`ifdef APU_CH1_SWEEP_EN
   assign wr10_s      = bus.apu_wr & bus.ff10;
   assign sw_clk_s    = fs_en_s & (fs_step_inc_s[1:0] == 2'b10);
   assign sw_reload_s = (nr10_r[6:4] == 3'd0) ? 4'd8 : {1'b0, nr10_r[6:4]};

   // Sweep unit state.
   always_ff @(posedge apuv_4mhz or negedge napu_reset) begin
      if (!napu_reset) begin
         nr10_r     <= 7'd0;
         shadow_r   <= {FREQ_W{1'b0}};
         sw_tmr_r   <= 4'd0;
         sweep_on_r <= 1'b0;
      end else begin
         nr10_r     <= nr10_nx;
         shadow_r   <= shadow_nx;
         sw_tmr_r   <= sw_tmr_nx;
         sweep_on_r <= sweep_on_nx;
      end
   end
`endif

   // Channel state registers.
   always_ff @(posedge apuv_4mhz or negedge napu_reset) begin
      if (!napu_reset) begin
         pre_r     <= 2'd0;
         freq_r    <= {FREQ_W{1'b0}};
         ftmr_r    <= {FREQ_W{1'b0}};
         idx_r     <= 3'd0;
         fs_step_r <= 3'd0;
         duty_r    <= 2'd0;
         nr12_r    <= 8'd0;
         len_en_r  <= 1'b0;
         len_r     <= LEN_ZERO;
         vol_r     <= 4'd0;
         env_tmr_r <= 4'd0;
         env_frz_r <= 1'b0;
         active_r  <= 1'b0;
         amp_n_r   <= 1'b1;
         out_r     <= 4'd0;
      end else begin
         pre_r     <= pre_r + 2'd1;
         freq_r    <= freq_nx;
         ftmr_r    <= ftmr_nx;
         idx_r     <= idx_nx;
         fs_step_r <= fs_step_nx;
         duty_r    <= duty_nx;
         nr12_r    <= nr12_nx;
         len_en_r  <= len_en_nx;
         len_r     <= len_nx;
         vol_r     <= vol_nx;
         env_tmr_r <= env_tmr_nx;
         env_frz_r <= env_frz_nx;
         active_r  <= active_nx;
         amp_n_r   <= amp_n_nx;
         out_r     <= out_nx;
      end
   end

   assign ch1_out      = out_r;
   assign nch1_active  = ~active_r;
   assign nch1_amp_en  = amp_n_r;
   assign bus.ch1_d_oe = bus.cpu_rd & sel_any_s;

   // Read-back mux; unused bits read as 1.
   always_comb begin
      if (!bus.ch1_d_oe) begin
         bus.ch1_d_out = 8'h00;
      end else if (bus.ff10) begin
`ifdef APU_CH1_SWEEP_EN
         bus.ch1_d_out = {1'b1, nr10_r};
`else
         bus.ch1_d_out = 8'hFF;
`endif
      end else if (bus.ff11) begin
         bus.ch1_d_out = {duty_r, 6'h3F};
      end else if (bus.ff12) begin
         bus.ch1_d_out = nr12_r;
      end else if (bus.ff13) begin
         bus.ch1_d_out = 8'hFF;
      end else begin
         bus.ch1_d_out = {1'b1, len_en_r, 6'h3F};
      end
   end
endmodule
